// File: rtl/cp0_ex_ctrl.sv
// rtl/cp0_ex_ctrl.sv - WB-stage exception/ERET sequencer driving CP0 updates, flush and fetch redirect
// Optional interrupt trigger enabled by defining CP0_INT_EN.
module cp0_ex_ctrl #(
    parameter logic [3:0]  FLUSH_CYCLES = 4'd2,
    parameter logic [31:0] EX_VECTOR    = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_valid,
    input  logic [31:0] ws_pc,
    input  logic        ws_bd,
    input  logic        ws_ex,
    input  logic [4:0]  ws_excode,
    input  logic        ws_eret,
    input  logic [5:0]  hw_int,
    output logic        ws_allowin,
    output logic [4:0]  cp0_raddr,
    input  logic [31:0] cp0_rdata,
    output logic [31:0] cp0_wdata,
    output logic [4:0]  cp0_excode,
    output logic [2:0]  cp0_ex_code,
    output logic        cp0_bd,
    output logic        cp0_eret,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_REDIRECT
    } state_t;

    state_t      r_state, w_next_state;
    logic [3:0]  r_cnt, w_next_cnt;
    logic [31:0] r_target, w_next_target;

    logic w_trig_ex, w_trig_eret, w_trig_int;

    // Triggers are suppressed while reset is held so CP0 never sees a stray update.
    assign w_trig_ex   = !reset && ws_valid && ws_ex;
    assign w_trig_eret = !reset && ws_valid && !ws_ex && ws_eret;

`ifdef CP0_INT_EN
    logic w_unused_rdata;
    assign w_unused_rdata = ^{cp0_rdata[31:16], cp0_rdata[9:2]};
    assign w_trig_int = !reset && ws_valid && !ws_ex && !ws_eret
                        && cp0_rdata[0] && !cp0_rdata[1]
                        && (|(hw_int & cp0_rdata[15:10]));
`else
    logic w_unused_hw_int;
    assign w_unused_hw_int = ^hw_int;
    assign w_trig_int = 1'b0;
`endif

    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        w_next_target  = r_target;
        ws_allowin     = 1'b0;
        cp0_raddr      = CP0_STATUS;
        cp0_wdata      = 32'd0;
        cp0_excode     = 5'd0;
        cp0_ex_code    = 3'b000;
        cp0_bd         = 1'b0;
        cp0_eret       = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        case (r_state)
            S_IDLE: begin
                ws_allowin = 1'b1;
                if (w_trig_ex) begin
                    cp0_ex_code   = 3'b001;
                    cp0_excode    = ws_excode;
                    cp0_bd        = ws_bd;
                    cp0_wdata     = ws_pc;
                    flush         = 1'b1;
                    w_next_target = EX_VECTOR;
                    w_next_cnt    = FLUSH_CYCLES;
                    w_next_state  = S_FLUSH;
                end else if (w_trig_eret) begin
                    // EPC must be captured now, before CP0 clears EXL at the end of this cycle.
                    cp0_eret      = 1'b1;
                    cp0_raddr     = CP0_EPC;
                    flush         = 1'b1;
                    w_next_target = cp0_rdata;
                    w_next_cnt    = FLUSH_CYCLES;
                    w_next_state  = S_FLUSH;
                end else if (w_trig_int) begin
                    cp0_ex_code   = 3'b010;
                    cp0_bd        = ws_bd;
                    cp0_wdata     = ws_pc;
                    flush         = 1'b1;
                    w_next_target = EX_VECTOR;
                    w_next_cnt    = FLUSH_CYCLES;
                    w_next_state  = S_FLUSH;
                end
            end
            S_FLUSH: begin
                flush      = 1'b1;
                w_next_cnt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_next_state = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = r_target;
                if (redirect_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_target <= 32'd0;
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_next_cnt;
            r_target <= w_next_target;
        end
    end

endmodule
